rob_rename_ctrl: RTL and testbench

ROB_RENAME_CTRL -- requirements
Module: rob_rename_ctrl

---
 rtl/rob_rename_ctrl_pkg.sv | 23 ++
 rtl/rob_map_tbl.sv | 58 +++++
 rtl/rob_rename_ctrl.sv | 158 +++++++++++++++
 tb/tb_rob_rename_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_rename_ctrl_pkg.sv
// Shared definitions for the ROB / rename controller: default sizes and the
// control-field layout of one ROB entry.
package rob_rename_ctrl_pkg;

    localparam int ROB_DEPTH   = 8;
    localparam int ROB_XLEN    = 32;
    localparam int ROB_NUM_CDB = 6;
    localparam int ROB_TW      = $clog2(ROB_DEPTH);
    localparam int NUM_REGS    = 32;

    typedef logic [4:0] reg_idx_t;

    // Entry data lives in a separate array so XLEN can be overridden per instance.
    typedef struct packed {
        logic     busy;
        logic     done;
        logic     wen;
        reg_idx_t rd;
    } rob_ctrl_t;

    localparam rob_ctrl_t ROB_CTRL_IDLE = '{busy: 1'b0, done: 1'b0, wen: 1'b0, rd: 5'd0};

endpackage

// File: rtl/rob_map_tbl.sv
// Architectural-register rename map: 32 x {valid, tag}, two read ports, one
// write port, a compare-and-clear port for commits, and a bulk flush clear.
module rob_map_tbl
    import rob_rename_ctrl_pkg::*;
#(
    parameter int TW = ROB_TW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  reg_idx_t      rd_addr_a,
    output logic          rd_valid_a,
    output logic [TW-1:0] rd_tag_a,
    input  reg_idx_t      rd_addr_b,
    output logic          rd_valid_b,
    output logic [TW-1:0] rd_tag_b,
    input  logic          wr_en,
    input  reg_idx_t      wr_addr,
    input  logic [TW-1:0] wr_tag,
    input  logic          clr_en,
    input  reg_idx_t      clr_addr,
    input  logic [TW-1:0] clr_tag
);

    logic          map_valid [NUM_REGS];
    logic [TW-1:0] map_tag   [NUM_REGS];

    // x0 is never written, so its valid bit stays clear and reads return unmapped.
    assign rd_valid_a = map_valid[rd_addr_a];
    assign rd_tag_a   = map_tag[rd_addr_a];
    assign rd_valid_b = map_valid[rd_addr_b];
    assign rd_tag_b   = map_tag[rd_addr_b];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                map_valid[r] <= 1'b0;
            end
        end else begin
            if (clr_en && map_valid[clr_addr] && (map_tag[clr_addr] == clr_tag)) begin
                map_valid[clr_addr] <= 1'b0;
            end
            // Later non-blocking write wins, so a same-cycle remap beats the clear.
            if (wr_en && (wr_addr != '0)) begin
                map_valid[wr_addr] <= 1'b1;
            end
        end
    end

    // NOTE: tags are only meaningful under a set valid bit, so this storage is
    // deliberately left without reset; only the valid bits need clearing.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr != '0)) begin
            map_tag[wr_addr] <= wr_tag;
        end
    end

endmodule

// File: rtl/rob_rename_ctrl.sv
// Reorder buffer with register renaming: in-order allocate/commit ring,
// multi-port CDB completion with forwarding, and a flushable rename map.
module rob_rename_ctrl
    import rob_rename_ctrl_pkg::*;
#(
    parameter int DEPTH   = ROB_DEPTH,
    parameter int XLEN    = ROB_XLEN,
    parameter int NUM_CDB = ROB_NUM_CDB,
    parameter int TW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic                    alloc_wen,
    input  logic [4:0]              alloc_rd,
    output logic [TW-1:0]           alloc_tag,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    output logic                    src1_busy,
    output logic                    src2_busy,
    output logic [TW-1:0]           src1_tag,
    output logic [TW-1:0]           src2_tag,
    output logic [XLEN-1:0]         src1_data,
    output logic [XLEN-1:0]         src2_data,
    input  logic [NUM_CDB-1:0]      cdb_valid,
    input  logic [NUM_CDB*TW-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0] cdb_data,
    output logic                    commit_valid,
    output logic [4:0]              commit_rd,
    output logic [XLEN-1:0]         commit_data,
    input  logic                    flush,
    output logic [TW:0]             count
);

    rob_ctrl_t       rob_ctrl [DEPTH];
    logic [XLEN-1:0] rob_data [DEPTH];
    logic [TW-1:0]   head, tail;
    logic [TW:0]     count_q;
    rob_ctrl_t       head_ent;
    logic            alloc_fire, commit_fire;
    logic            cdb_hit      [DEPTH];
    logic [XLEN-1:0] cdb_hit_data [DEPTH];
    logic            m1_valid, m2_valid;
    logic [TW-1:0]   m1_tag, m2_tag;

    assign head_ent    = rob_ctrl[head];
    assign alloc_ready = (count_q != (TW+1)'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign commit_fire = rst_n && !flush && head_ent.busy && head_ent.done;
    assign alloc_tag   = tail;
    assign count       = count_q;

    assign commit_valid = commit_fire;
    assign commit_rd    = (commit_fire && head_ent.wen) ? head_ent.rd : '0;
    assign commit_data  = commit_fire ? rob_data[head] : '0;

    // Per-entry CDB match, shared by completion and source forwarding.
    // NOTE: combinational blocks use blocking assignments with every output
    // defaulted first, so no path can leave a latch behind.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            cdb_hit[e]      = 1'b0;
            cdb_hit_data[e] = '0;
            // Scan high-to-low so the lowest matching port is the one that sticks.
            for (int i = NUM_CDB - 1; i >= 0; i--) begin
                if (cdb_valid[i] && (cdb_tag[i*TW +: TW] == TW'(e))) begin
                    cdb_hit[e]      = 1'b1;
                    cdb_hit_data[e] = cdb_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    rob_map_tbl #(.TW(TW)) u_map (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .rd_addr_a  (rs1),
        .rd_valid_a (m1_valid),
        .rd_tag_a   (m1_tag),
        .rd_addr_b  (rs2),
        .rd_valid_b (m2_valid),
        .rd_tag_b   (m2_tag),
        .wr_en      (alloc_fire && alloc_wen),
        .wr_addr    (alloc_rd),
        .wr_tag     (tail),
        .clr_en     (commit_fire && head_ent.wen),
        .clr_addr   (head_ent.rd),
        .clr_tag    (head)
    );

    always_comb begin
        src1_busy = 1'b0;
        src1_tag  = '0;
        src1_data = '0;
        if (m1_valid) begin
            src1_tag = m1_tag;
            if (rob_ctrl[m1_tag].done)  src1_data = rob_data[m1_tag];
            else if (cdb_hit[m1_tag])   src1_data = cdb_hit_data[m1_tag];
            else                        src1_busy = 1'b1;
        end
    end

    always_comb begin
        src2_busy = 1'b0;
        src2_tag  = '0;
        src2_data = '0;
        if (m2_valid) begin
            src2_tag = m2_tag;
            if (rob_ctrl[m2_tag].done)  src2_data = rob_data[m2_tag];
            else if (cdb_hit[m2_tag])   src2_data = cdb_hit_data[m2_tag];
            else                        src2_busy = 1'b1;
        end
    end

    // Completion, commit and allocation always target distinct entries: the
    // head is already done, and the tail is idle whenever allocation is allowed.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                rob_ctrl[e] <= ROB_CTRL_IDLE;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (cdb_hit[e] && rob_ctrl[e].busy && !rob_ctrl[e].done) begin
                    rob_ctrl[e].done <= 1'b1;
                end
            end
            if (commit_fire) begin
                rob_ctrl[head] <= ROB_CTRL_IDLE;
                head           <= head + TW'(1);
            end
            if (alloc_fire) begin
                rob_ctrl[tail] <= '{busy: 1'b1, done: 1'b0,
                                   wen: alloc_wen && (alloc_rd != '0), rd: alloc_rd};
                tail           <= tail + TW'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + (TW+1)'(1);
                2'b01:   count_q <= count_q - (TW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (cdb_hit[e] && rob_ctrl[e].busy && !rob_ctrl[e].done) begin
                rob_data[e] <= cdb_hit_data[e];
            end
        end
    end

endmodule

// File: tb/tb_rob_rename_ctrl.sv
// Self-checking bench for rob_rename_ctrl: a reference ROB/map model plus a
// commit scoreboard, directed scenarios and a randomized phase.
module tb_rob_rename_ctrl;

    localparam int DEPTH   = 8;
    localparam int XLEN    = 32;
    localparam int NUM_CDB = 6;
    localparam int TW      = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    alloc_valid, alloc_ready, alloc_wen;
    logic [4:0]              alloc_rd;
    logic [TW-1:0]           alloc_tag;
    logic [4:0]              rs1, rs2;
    logic                    src1_busy, src2_busy;
    logic [TW-1:0]           src1_tag, src2_tag;
    logic [XLEN-1:0]         src1_data, src2_data;
    logic [NUM_CDB-1:0]      cdb_valid;
    logic [NUM_CDB*TW-1:0]   cdb_tag;
    logic [NUM_CDB*XLEN-1:0] cdb_data;
    logic                    commit_valid;
    logic [4:0]              commit_rd;
    logic [XLEN-1:0]         commit_data;
    logic                    flush;
    logic [TW:0]             count;

    rob_rename_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_CDB(NUM_CDB), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_wen(alloc_wen),
        .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .rs1(rs1), .rs2(rs2),
        .src1_busy(src1_busy), .src2_busy(src2_busy),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .src1_data(src1_data), .src2_data(src2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    bit              exp_busy [DEPTH];
    bit              exp_done [DEPTH];
    int              exp_rd   [DEPTH];
    logic [XLEN-1:0] exp_data [DEPTH];
    bit              map_v    [32];
    int              map_t    [32];
    int              mdl_tail  = 0;
    int              mdl_count = 0;
    int              sb_q [$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [4:0] rs, output bit busy, output int tg,
                                   output logic [XLEN-1:0] d);
        busy = 1'b0; tg = 0; d = '0;
        if (rs != 0 && map_v[rs]) begin
            tg = map_t[rs];
            if (exp_done[tg]) d = exp_data[tg];
            else begin
                busy = 1'b1;
                for (int i = 0; i < NUM_CDB; i++) begin
                    if (busy && cdb_valid[i] && int'(cdb_tag[i*TW +: TW]) == tg) begin
                        busy = 1'b0;
                        d    = cdb_data[i*XLEN +: XLEN];
                    end
                end
            end
        end
    endfunction

    task automatic clear_model();
        for (int e = 0; e < DEPTH; e++) begin exp_busy[e] = 0; exp_done[e] = 0; end
        for (int r = 0; r < 32; r++) map_v[r] = 0;
        sb_q.delete();
        mdl_tail  = 0;
        mdl_count = 0;
    endtask

    // Called just before each rising edge: compare outputs, then advance the model.
    task automatic mon();
        bit              b1, b2, exp_cv, full_pre;
        int              t1, t2, t;
        logic [XLEN-1:0] d1, d2;
        bit [DEPTH-1:0]  wr;
        lookup(rs1, b1, t1, d1);
        lookup(rs2, b2, t2, d2);
        check("src1_busy", src1_busy, b1);
        check("src1_tag",  src1_tag,  t1);
        check("src1_data", src1_data, d1);
        check("src2_busy", src2_busy, b2);
        check("src2_tag",  src2_tag,  t2);
        check("src2_data", src2_data, d2);
        exp_cv = rst_n && !flush && sb_q.size() != 0 && exp_done[sb_q[0]];
        check("commit_valid", commit_valid, exp_cv);
        check("count",        count,        mdl_count);
        check("alloc_ready",  alloc_ready,  mdl_count != DEPTH);
        check("alloc_tag",    alloc_tag,    mdl_tail);
        if (!rst_n || flush) begin
            clear_model();
            return;
        end
        full_pre = (mdl_count == DEPTH);
        if (exp_cv) begin
            t = sb_q.pop_front();
            check("commit_rd",   commit_rd,   exp_rd[t]);
            check("commit_data", commit_data, exp_data[t]);
            exp_busy[t] = 0;
            mdl_count--;
            if (exp_rd[t] != 0 && map_v[exp_rd[t]] && map_t[exp_rd[t]] == t) map_v[exp_rd[t]] = 0;
        end
        wr = '0;
        for (int i = 0; i < NUM_CDB; i++) begin
            if (cdb_valid[i]) begin
                t = int'(cdb_tag[i*TW +: TW]);
                if (!wr[t]) begin
                    wr[t] = 1'b1;
                    if (exp_busy[t] && !exp_done[t]) begin
                        exp_done[t] = 1;
                        exp_data[t] = cdb_data[i*XLEN +: XLEN];
                    end
                end
            end
        end
        if (alloc_valid && !full_pre) begin
            t = mdl_tail;
            exp_busy[t] = 1;
            exp_done[t] = 0;
            exp_rd[t]   = (alloc_wen && alloc_rd != 0) ? int'(alloc_rd) : 0;
            sb_q.push_back(t);
            if (exp_rd[t] != 0) begin map_v[exp_rd[t]] = 1; map_t[exp_rd[t]] = t; end
            mdl_tail = (mdl_tail + 1) % DEPTH;
            mdl_count++;
        end
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_wen = 0; alloc_rd = '0;
        rs1 = '0; rs2 = '0; flush = 0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic settle(); @(negedge clk); mon(); endtask
    task automatic adv();    @(posedge clk); #1; idle(); endtask
    task automatic cyc();    settle(); adv(); endtask

    task automatic alloc(input bit wen, input int rd);
        alloc_valid = 1; alloc_wen = wen; alloc_rd = 5'(rd);
    endtask

    task automatic set_cdb(input int port, input int tg, input logic [XLEN-1:0] d);
        cdb_valid[port]             = 1'b1;
        cdb_tag[port*TW +: TW]      = TW'(tg);
        cdb_data[port*XLEN +: XLEN] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        clear_model();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Reset state
        settle();
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_tag",   alloc_tag,   0);
        check("rst_commit_rd",   commit_rd,   0);
        check("rst_commit_data", commit_data, 0);
        check("rst_count",       count,       0);
        adv();

        // First allocation and lookup, then fill the ROB
        alloc(1, 5); settle(); check("first_tag", alloc_tag, 0); adv();
        rs1 = 5; alloc(1, 9); settle();
        check("r35_busy", src1_busy, 1); check("r35_tag", src1_tag, 0); adv();
        for (int k = 2; k < DEPTH; k++) begin alloc(1, 8 + k); cyc(); end

        // Full: allocation waits, CDB completes the head
        alloc(1, 20); set_cdb(0, 0, 32'h1234); settle();
        check("full_count", count, 8); check("full_ready", alloc_ready, 0); adv();
        alloc(1, 20); rs2 = 5; settle();
        check("r36_cv", commit_valid, 1); check("r36_rd", commit_rd, 5);
        check("r36_data", commit_data, 32'h1234);
        check("r36_ready_during_commit", alloc_ready, 0);
        check("r36_fwd_done", src2_data, 32'h1234); adv();
        rs2 = 5; settle();
        check("r36_ready_after", alloc_ready, 1); check("r36_count_after", count, 7);
        check("map_cleared_busy", src2_busy, 0); adv();

        // Same-tag collision on ports 0 and 3
        set_cdb(0, 4, 32'hA); set_cdb(3, 4, 32'hB); rs1 = 12; settle();
        check("r39_fwd_busy", src1_busy, 0); check("r39_fwd_data", src1_data, 32'hA); adv();
        alloc(1, 12); rs1 = 12; settle();
        check("r39_stored", src1_data, 32'hA); check("old_mapping", src1_tag, 4);
        check("wrap_tag", alloc_tag, 0); adv();
        rs1 = 12; settle(); check("remap_tag", src1_tag, 0); check("remap_busy", src1_busy, 1); adv();
        flush = 1; cyc();

        // Out-of-order completion, in-order commit, map invalidation
        alloc(1, 3); cyc();
        alloc(1, 3); cyc();
        alloc(1, 9); rs1 = 3; settle(); check("r38_latest", src1_tag, 1); adv();
        alloc(0, 7); set_cdb(2, 2, 32'h22); cyc();
        alloc(1, 0); set_cdb(1, 1, 32'h11); rs1 = 0; settle(); check("x0_busy", src1_busy, 0); adv();
        set_cdb(5, 0, 32'h10); rs1 = 3; settle();
        check("r37_no_early", commit_valid, 0); check("r38_fwd", src1_data, 32'h11); adv();
        rs1 = 3; settle();
        check("r37_c0", commit_data, 32'h10); check("r38_keep", src1_tag, 1); adv();
        settle(); check("r37_c1", commit_data, 32'h11); adv();
        rs1 = 3; alloc(1, 9); settle();
        check("r37_c2", commit_data, 32'h22); check("r38_free", src1_busy, 0); adv();
        rs1 = 9; settle(); check("alloc_wins", src1_tag, 5); adv();
        set_cdb(0, 3, 32'h33); set_cdb(1, 4, 32'h44); cyc();
        settle(); check("nowen_rd", commit_rd, 0); adv();
        settle(); check("x0_commit_rd", commit_rd, 0); adv();

        // Flush with a completed head
        flush = 1; cyc();
        for (int k = 1; k <= 5; k++) begin alloc(1, k); cyc(); end
        set_cdb(0, 0, 32'h55); cyc();
        flush = 1; settle(); check("r40_no_commit", commit_valid, 0); adv();
        rs1 = 1; rs2 = 2; settle();
        check("r40_count", count, 0); check("r40_tag", alloc_tag, 0);
        check("r40_busy1", src1_busy, 0); check("r40_busy2", src2_busy, 0); adv();

        // Reset in the middle of operation
        alloc(1, 6); cyc();
        set_cdb(0, 0, 32'h66); cyc();
        rst_n = 0; settle(); check("midrst_no_commit", commit_valid, 0); adv();
        rst_n = 1; rs1 = 6; settle(); check("midrst_count", count, 0); adv();

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) != 0) alloc(1'($urandom_range(0, 1)), $urandom_range(0, 31));
            for (int p = 0; p < NUM_CDB; p++) begin
                if ($urandom_range(0, 4) == 0) set_cdb(p, $urandom_range(0, DEPTH - 1), $urandom);
            end
            rs1   = 5'($urandom_range(0, 31));
            rs2   = 5'($urandom_range(0, 31));
            flush = ($urandom_range(0, 63) == 0);
            cyc();
        end

        // Drain
        for (int n = 0; n < 40; n++) begin
            if (sb_q.size() != 0) set_cdb(0, sb_q[0], $urandom);
            rs1 = 5'($urandom_range(0, 31));
            cyc();
        end
        settle(); check("drain_count", count, 0); adv();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
